// File: rtl/bt_cmd_pkg.sv
// Shared opcode constants and UART receiver state encoding for the Bluetooth command front end.
package bt_cmd_pkg;

  localparam logic [7:0] OP_NEXT     = 8'h01;
  localparam logic [7:0] OP_PREV     = 8'h02;
  localparam logic [7:0] OP_VOL_UP   = 8'h03;
  localparam logic [7:0] OP_VOL_DN   = 8'h04;
  localparam logic [7:0] OP_VOL_RST  = 8'h05;
  localparam logic [7:0] OP_SEL_BASE = 8'h10;

  typedef enum logic [2:0] {
    RX_IDLE      = 3'd0,
    RX_START     = 3'd1,
    RX_DATA      = 3'd2,
    RX_STOP      = 3'd3,
    RX_WAIT_IDLE = 3'd4
  } rx_state_t;

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: 2-flop synchroniser, baud counter, and framing FSM producing a
// one-cycle byte strobe or frame-error pulse.
module uart_rx_core
  import bt_cmd_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10416
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  output logic [7:0] rx_byte,
  output logic       rx_strobe,
  output logic       rx_frame_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic [1:0]       sync_reg;
  rx_state_t        state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [2:0]       bit_idx_reg, bit_idx_next;
  logic [7:0]       shift_reg, shift_next;
  logic             rxd_s;

  assign rxd_s   = sync_reg[1];
  assign rx_byte = shift_reg;

  // Synchroniser resets to the idle-high level so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_reg    <= 2'b11;
      state_reg   <= RX_IDLE;
      cnt_reg     <= '0;
      bit_idx_reg <= '0;
      shift_reg   <= '0;
    end else begin
      sync_reg    <= {sync_reg[0], rxd};
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      bit_idx_reg <= bit_idx_next;
      shift_reg   <= shift_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    bit_idx_next = bit_idx_reg;
    shift_next   = shift_reg;
    rx_strobe    = 1'b0;
    rx_frame_err = 1'b0;
    case (state_reg)
      RX_IDLE: begin
        cnt_next     = '0;
        bit_idx_next = '0;
        if (!rxd_s) state_next = RX_START;
      end
      RX_START: begin
        if (cnt_reg == CNT_HALF) begin
          cnt_next   = '0;
          state_next = rxd_s ? RX_IDLE : RX_DATA;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (cnt_reg == CNT_FULL) begin
          cnt_next     = '0;
          shift_next   = {rxd_s, shift_reg[7:1]};
          bit_idx_next = bit_idx_reg + 3'd1;
          if (bit_idx_reg == 3'd7) state_next = RX_STOP;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (cnt_reg == CNT_FULL) begin
          cnt_next = '0;
          if (rxd_s) begin
            rx_strobe  = 1'b1;
            state_next = RX_IDLE;
          end else begin
            rx_frame_err = 1'b1;
            state_next   = RX_WAIT_IDLE;
          end
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      RX_WAIT_IDLE: begin
        if (rxd_s) state_next = RX_IDLE;
      end
      default: state_next = RX_IDLE;
    endcase
  end

endmodule

// File: rtl/bt_uart_cmd.sv
// Bluetooth remote command decoder: UART bytes -> SCI_VOL volume word and song index.
// Optional BT_DIRECT_SEL_EN enables direct song select opcodes 8'h10..8'h17.
module bt_uart_cmd
  import bt_cmd_pkg::*;
#(
  parameter int         CLK_HZ    = 100_000_000,
  parameter int         BAUD      = 9600,
  parameter int         NUM_SONGS = 5,
  parameter logic [7:0] VOL_INIT  = 8'h20,
  parameter logic [7:0] VOL_STEP  = 8'h08,
  parameter logic [7:0] VOL_MAX   = 8'hF0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        RXD,
  output logic [15:0] vol,
  output logic [2:0]  CURRENT,
  output logic        cmd_valid,
  output logic        frame_err
);

  localparam int         CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam logic [2:0] LAST_SONG    = 3'(NUM_SONGS - 1);

  logic [7:0] rx_byte;
  logic       rx_strobe, rx_frame_err;
  logic [7:0] att_reg, att_next;
  logic [2:0] current_reg, current_next;
  logic       cmd_valid_reg, cmd_valid_next;
  logic       frame_err_reg;
  logic [8:0] att_up9, att_dn9;

  uart_rx_core #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk         (CLK),
    .rst_n       (RST),
    .rxd         (RXD),
    .rx_byte     (rx_byte),
    .rx_strobe   (rx_strobe),
    .rx_frame_err(rx_frame_err)
  );

  // Bit 8 of the subtraction is the borrow, i.e. att < VOL_STEP.
  assign att_up9 = {1'b0, att_reg} - {1'b0, VOL_STEP};
  assign att_dn9 = {1'b0, att_reg} + {1'b0, VOL_STEP};

  always_comb begin
    att_next       = att_reg;
    current_next   = current_reg;
    cmd_valid_next = 1'b0;
    if (rx_strobe) begin
      cmd_valid_next = 1'b1;
      case (rx_byte)
        OP_NEXT:    current_next = (current_reg == LAST_SONG) ? 3'd0 : current_reg + 3'd1;
        OP_PREV:    current_next = (current_reg == 3'd0) ? LAST_SONG : current_reg - 3'd1;
        OP_VOL_UP:  att_next = att_up9[8] ? 8'h00 : att_up9[7:0];
        OP_VOL_DN:  att_next = (att_dn9 > {1'b0, VOL_MAX}) ? VOL_MAX : att_dn9[7:0];
        OP_VOL_RST: att_next = VOL_INIT;
        default: begin
          cmd_valid_next = 1'b0;
`ifdef BT_DIRECT_SEL_EN
          if (rx_byte[7:3] == OP_SEL_BASE[7:3] && int'(rx_byte[2:0]) < NUM_SONGS) begin
            current_next   = rx_byte[2:0];
            cmd_valid_next = 1'b1;
          end
`endif
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      att_reg       <= VOL_INIT;
      current_reg   <= 3'd0;
      cmd_valid_reg <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      att_reg       <= att_next;
      current_reg   <= current_next;
      cmd_valid_reg <= cmd_valid_next;
      frame_err_reg <= rx_frame_err;
    end
  end

  // Same attenuation byte on left and right channels.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_vol_chan
      assign vol[gi*8 +: 8] = att_reg;
    end
  endgenerate

  assign CURRENT   = current_reg;
  assign cmd_valid = cmd_valid_reg;
  assign frame_err = frame_err_reg;

endmodule

// File: tb/tb_bt_uart_cmd.sv
// Self-checking bench for bt_uart_cmd: bit-banged UART frames against a behavioural command model.
module tb_bt_uart_cmd;

  localparam int CLK_HZ = 1600;
  localparam int BAUD   = 100;
  localparam int CPB    = CLK_HZ / BAUD;
  localparam int NS     = 5;
  localparam int INIT   = 8'h20;
  localparam int STEP   = 8'h08;
  localparam int VMAX   = 8'hF0;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        RXD = 1'b1;
  logic [15:0] vol;
  logic [2:0]  CURRENT;
  logic        cmd_valid, frame_err;

  int compared = 0;
  int mismatched = 0;
  int cv_cnt = 0;
  int fe_cnt = 0;
  int m_att = INIT;
  int m_cur = 0;

  bt_uart_cmd #(
    .CLK_HZ(CLK_HZ), .BAUD(BAUD), .NUM_SONGS(NS),
    .VOL_INIT(8'h20), .VOL_STEP(8'h08), .VOL_MAX(8'hF0)
  ) dut (
    .CLK(CLK), .RST(RST), .RXD(RXD), .vol(vol), .CURRENT(CURRENT),
    .cmd_valid(cmd_valid), .frame_err(frame_err)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (cmd_valid === 1'b1) cv_cnt++;
    if (frame_err === 1'b1) fe_cnt++;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: sim time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  // Reference model: applies one received byte using the command rules directly.
  task automatic model_apply(input logic [7:0] b, output int valid);
    valid = 1;
    case (b)
      8'h01: m_cur = (m_cur + 1) % NS;
      8'h02: m_cur = (m_cur + NS - 1) % NS;
      8'h03: m_att = (m_att < STEP) ? 0 : m_att - STEP;
      8'h04: m_att = (m_att + STEP > VMAX) ? VMAX : m_att + STEP;
      8'h05: m_att = INIT;
      default: begin
        valid = 0;
`ifdef BT_DIRECT_SEL_EN
        if (b >= 8'h10 && b <= 8'h17 && (int'(b) - 16) < NS) begin
          m_cur = int'(b) - 16;
          valid = 1;
        end
`endif
      end
    endcase
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    RXD = 1'b0;
    repeat (CPB) @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      RXD = b[i];
      repeat (CPB) @(negedge CLK);
    end
    RXD = stop_bit;
    repeat (CPB) @(negedge CLK);
    RXD = 1'b1;
    repeat (4) @(negedge CLK);
  endtask

  task automatic do_reset();
    RST = 1'b0;
    RXD = 1'b1;
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    m_att = INIT;
    m_cur = 0;
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_reset();
    RST = 1'b0;
    RXD = 1'b1;
    repeat (3) @(negedge CLK);
    compared++;
    if (cmd_valid !== 1'b0 || frame_err !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_pulses: cmd_valid=%b frame_err=%b expected 0 0", cmd_valid, frame_err);
    end
    RST = 1'b1;
    m_att = INIT;
    m_cur = 0;
    @(negedge CLK);
    compared++;
    if (vol !== 16'h2020) begin
      mismatched++;
      $display("FAIL reset_vol: vol=%h expected 2020", vol);
    end
    compared++;
    if (CURRENT !== 3'd0) begin
      mismatched++;
      $display("FAIL reset_current: CURRENT=%0d expected 0", CURRENT);
    end
    $display("txn reset vol=%h CURRENT=%0d", vol, CURRENT);
  endtask

  task automatic test_vol();
    int v, c0;
    logic [15:0] exp_vol;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      c0 = cv_cnt;
      send_byte(8'h03, 1'b1);
      model_apply(8'h03, v);
      exp_vol = {m_att[7:0], m_att[7:0]};
      $display("txn vol_up[%0d] vol=%h", k, vol);
      compared++;
      if (vol !== exp_vol || cv_cnt - c0 != 1) begin
        mismatched++;
        $display("FAIL vol_up: vol=%h pulses=%0d expected %h 1", vol, cv_cnt - c0, exp_vol);
      end
    end
    compared++;
    if (vol !== 16'h0000) begin
      mismatched++;
      $display("FAIL vol_up_clamp: vol=%h expected 0000", vol);
    end
    c0 = cv_cnt;
    for (int k = 0; k < 32; k++) begin
      send_byte(8'h04, 1'b1);
      model_apply(8'h04, v);
    end
    $display("txn vol_dn x32 vol=%h", vol);
    compared++;
    if (vol !== 16'hF0F0 || cv_cnt - c0 != 32) begin
      mismatched++;
      $display("FAIL vol_dn_clamp: vol=%h pulses=%0d expected f0f0 32", vol, cv_cnt - c0);
    end
    send_byte(8'h05, 1'b1);
    model_apply(8'h05, v);
    compared++;
    if (vol !== 16'h2020) begin
      mismatched++;
      $display("FAIL vol_rst: vol=%h expected 2020", vol);
    end
  endtask

  task automatic test_songs();
    int v;
    int exp_seq[6] = '{1, 2, 3, 4, 0, 4};
    do_reset();
    for (int k = 0; k < 6; k++) begin
      send_byte(k < 5 ? 8'h01 : 8'h02, 1'b1);
      model_apply(k < 5 ? 8'h01 : 8'h02, v);
      $display("txn song[%0d] CURRENT=%0d", k, CURRENT);
      compared++;
      if (CURRENT !== 3'(exp_seq[k]) || m_cur != exp_seq[k]) begin
        mismatched++;
        $display("FAIL song_step: CURRENT=%0d expected %0d", CURRENT, exp_seq[k]);
      end
    end
  endtask

  task automatic test_frame_err();
    int v, c0, f0;
    logic [2:0] cur0;
    cur0 = CURRENT;
    c0 = cv_cnt;
    f0 = fe_cnt;
    send_byte(8'h01, 1'b0);
    $display("txn bad_stop CURRENT=%0d fe=%0d", CURRENT, fe_cnt - f0);
    compared++;
    if (fe_cnt - f0 != 1 || cv_cnt != c0 || CURRENT !== 3'(m_cur)) begin
      mismatched++;
      $display("FAIL frame_err: fe=%0d cv=%0d CURRENT=%0d expected 1 0 %0d",
               fe_cnt - f0, cv_cnt - c0, CURRENT, cur0);
    end
    send_byte(8'h01, 1'b1);
    model_apply(8'h01, v);
    compared++;
    if (CURRENT !== 3'(m_cur) || cv_cnt - c0 != 1) begin
      mismatched++;
      $display("FAIL after_frame_err: CURRENT=%0d expected %0d", CURRENT, m_cur);
    end
  endtask

  task automatic test_glitch_and_abort();
    int v, c0, f0;
    c0 = cv_cnt;
    f0 = fe_cnt;
    RXD = 1'b0;
    repeat (CPB / 4) @(negedge CLK);
    RXD = 1'b1;
    repeat (2 * CPB) @(negedge CLK);
    $display("txn glitch cv=%0d fe=%0d", cv_cnt - c0, fe_cnt - f0);
    compared++;
    if (cv_cnt != c0 || fe_cnt != f0 || CURRENT !== 3'(m_cur) || vol !== {m_att[7:0], m_att[7:0]}) begin
      mismatched++;
      $display("FAIL glitch: cv=%0d fe=%0d CURRENT=%0d expected 0 0 %0d",
               cv_cnt - c0, fe_cnt - f0, CURRENT, m_cur);
    end
    // Start a byte, then reset partway through the data bits.
    RXD = 1'b0;
    repeat (CPB) @(negedge CLK);
    for (int i = 0; i < 4; i++) begin
      RXD = (i == 0);
      repeat (CPB) @(negedge CLK);
    end
    do_reset();
    repeat (12 * CPB) @(negedge CLK);
    $display("txn abort vol=%h CURRENT=%0d", vol, CURRENT);
    compared++;
    if (cv_cnt != c0 || fe_cnt != f0 || CURRENT !== 3'd0 || vol !== 16'h2020) begin
      mismatched++;
      $display("FAIL mid_byte_reset: cv=%0d fe=%0d CURRENT=%0d vol=%h expected 0 0 0 2020",
               cv_cnt - c0, fe_cnt - f0, CURRENT, vol);
    end
    send_byte(8'h01, 1'b1);
    model_apply(8'h01, v);
    compared++;
    if (CURRENT !== 3'(m_cur)) begin
      mismatched++;
      $display("FAIL after_abort: CURRENT=%0d expected %0d", CURRENT, m_cur);
    end
  endtask

  task automatic test_direct_sel();
    int v, c0;
    logic [7:0] ops[2] = '{8'h12, 8'h17};
    do_reset();
    for (int k = 0; k < 2; k++) begin
      c0 = cv_cnt;
      send_byte(ops[k], 1'b1);
      model_apply(ops[k], v);
      $display("txn sel op=%h CURRENT=%0d", ops[k], CURRENT);
      compared++;
      if (CURRENT !== 3'(m_cur) || cv_cnt - c0 != v) begin
        mismatched++;
        $display("FAIL direct_sel: op=%h CURRENT=%0d pulses=%0d expected %0d %0d",
                 ops[k], CURRENT, cv_cnt - c0, m_cur, v);
      end
    end
`ifdef BT_DIRECT_SEL_EN
    compared++;
    if (CURRENT !== 3'd2) begin
      mismatched++;
      $display("FAIL direct_sel_value: CURRENT=%0d expected 2", CURRENT);
    end
`else
    compared++;
    if (CURRENT !== 3'd0) begin
      mismatched++;
      $display("FAIL direct_sel_disabled: CURRENT=%0d expected 0", CURRENT);
    end
`endif
  endtask

  task automatic test_random();
    int v, c0, f0, sel, exp_fe;
    logic [7:0] b;
    logic stop;
    do_reset();
    for (int k = 0; k < 40; k++) begin
      sel = $urandom_range(0, 9);
      if (sel < 5) b = 8'(sel + 1);
      else if (sel < 7) b = 8'(8'h10 + $urandom_range(0, 7));
      else b = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 9) != 0);
      c0 = cv_cnt;
      f0 = fe_cnt;
      send_byte(b, stop);
      if (stop) model_apply(b, v);
      else v = 0;
      exp_fe = stop ? 0 : 1;
      $display("txn rand[%0d] byte=%h stop=%b vol=%h CURRENT=%0d", k, b, stop, vol, CURRENT);
      compared++;
      if (vol !== {m_att[7:0], m_att[7:0]} || CURRENT !== 3'(m_cur) ||
          cv_cnt - c0 != v || fe_cnt - f0 != exp_fe) begin
        mismatched++;
        $display("FAIL random: byte=%h vol=%h CURRENT=%0d cv=%0d fe=%0d expected %h %0d %0d %0d",
                 b, vol, CURRENT, cv_cnt - c0, fe_cnt - f0,
                 {m_att[7:0], m_att[7:0]}, m_cur, v, exp_fe);
      end
    end
  endtask

  initial begin
    test_reset();
    test_vol();
    test_songs();
    test_frame_err();
    test_glitch_and_abort();
    test_direct_sel();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
